crossbar_la_ctrl: RTL and testbench
===================================

CROSSBAR_LA_CTRL -- requirements
Module: crossbar_la_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2, setting idle-driver cycles after each pulse (legal 1..15).
REQ-002 SHALL have port clock  input  1  sole clock; all state on rising edge.
REQ-003 SHALL have port resetb  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port la_data_in  input  32  LA command word: [2:0] row, [5:3] col, [7:6] op (00 NOP, 01 SET, 10 RESET, 11 READ), [15:8] pw (pulse cycles), [16] go.
REQ-005 SHALL have port la_oenb  input  32  LA output-enable-bar; bit low means the management SoC drives that la_data_in bit.
REQ-006 SHALL have port la_data_out  output  32  status: [0] busy, [1] done, [2] err, [3] read bit, [11:4] sense byte, [19:12] op_count, [31:20] zero.
REQ-007 SHALL have port wl_en  output  8  one-hot word-line enable.
REQ-008 SHALL have port bl_set  output  8  one-hot bit-line SET driver enable.
REQ-009 SHALL have port bl_rst  output  8  one-hot bit-line RESET driver enable.
REQ-010 SHALL have port sense_en  output  1  read sense-amp enable.
REQ-011 SHALL have port sense_in  input  8  per-bit-line comparator outputs, valid while sense_en high.

Function
REQ-012 SHALL register go into go_q every cycle; start = go & ~go_q & (la_oenb[16:0] == 0).
REQ-013 SHALL ignore start without error when la_oenb[16:0] is nonzero or op is NOP.
REQ-014 SHALL accept start in IDLE with op != NOP and pw != 0: latch row/col/op/pw, clear done and err, enter SETUP on the same edge.
REQ-015 SHALL reject start with pw == 0, or any start while busy: set err sticky, leave the current operation and latched fields untouched.
REQ-016 SHALL implement FSM IDLE -> SETUP (1 cycle) -> PULSE (pw cycles) -> SETTLE (SETTLE_CYCLES cycles) -> IDLE.
REQ-017 SHALL drive wl_en = one-hot(row) in SETUP and PULSE, zero otherwise.
REQ-018 SHALL in PULSE drive bl_set = one-hot(col) for SET, bl_rst = one-hot(col) for RESET, sense_en = 1 for READ; all zero in other states.
REQ-019 SHALL never assert bl_set and bl_rst in the same cycle, and never assert any bit-line driver or sense_en while wl_en is zero.
REQ-020 SHALL count PULSE with an 8-bit down-counter loaded with pw on SETUP exit, leaving PULSE when count == 1.
REQ-021 SHALL on the last PULSE cycle of a READ capture sense_in into the sense byte and sense_in[col] into the read bit; SET/RESET leave both unchanged.
REQ-022 SHALL hold busy high in SETUP, PULSE and SETTLE: exactly 1 + pw + SETTLE_CYCLES cycles per accepted op.
REQ-023 SHALL on SETTLE -> IDLE set done (sticky until next accepted start) and increment op_count, 8-bit, wrapping 255 -> 0.
REQ-024 SHALL register all outputs (no combinational path from la_data_in to any output).
REQ-025 SHALL allow a new start on the first IDLE cycle after SETTLE (back-to-back ops, provided go returned low).

Reset
REQ-026 SHALL on resetb low asynchronously return to IDLE and zero wl_en, bl_set, bl_rst, sense_en, la_data_out, op_count, the latched fields and the pulse counter.
REQ-027 SHALL reset go_q to 1, so a go held high through reset release does not start an op; go must fall and rise again.
REQ-028 SHALL abort any in-flight op on reset without setting done or incrementing op_count.

Verification
REQ-029 SHALL cover: reset asserted -> la_data_out = 0, wl_en/bl_set/bl_rst = 0, sense_en = 0.
REQ-030 SHALL cover: SET row 3 col 5 pw 4 -> wl_en = 0x08 for 5 cycles, bl_set = 0x20 for exactly 4 cycles, busy 7 cycles, then done = 1, op_count = 1.
REQ-031 SHALL cover: READ row 0 col 7 pw 1, sense_in = 0x80 -> sense_en 1 cycle, la_data_out[3] = 1, la_data_out[11:4] = 0x80.
REQ-032 SHALL cover: RESET start during a busy SET, then start with pw = 0 -> err = 1, SET completes unchanged, no extra busy period, bl_rst stays 0.
REQ-033 SHALL cover: resetb low mid-PULSE with go held high -> drivers 0 immediately, done = 0, op_count unchanged, no op after release until go toggles.
REQ-034 SHALL cover: 256 back-to-back SETs -> op_count wraps to 0; go rise with la_oenb[16] = 1 -> no op, err unchanged.

Source files
------------

// File: rtl/crossbar_la_ctrl.sv
// Crossbar array pulse controller driven from the logic-analyzer port.
// Runs one SET/RESET/READ pulse per go edge and reports status on la_data_out.
module crossbar_la_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic        clock,
  input  logic        resetb,
  input  logic [31:0] la_data_in,
  input  logic [31:0] la_oenb,
  output logic [31:0] la_data_out,
  output logic [7:0]  wl_en,
  output logic [7:0]  bl_set,
  output logic [7:0]  bl_rst,
  output logic        sense_en,
  input  logic [7:0]  sense_in
);

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_PULSE, ST_SETTLE} state_t;
  typedef enum logic [1:0] {OP_NOP, OP_SET, OP_RESET, OP_READ} op_t;

  state_t     state, state_nx;
  op_t        cmd_op, op_q, op_d;
  logic [2:0] cmd_row, cmd_col, row_q, row_d, col_q, col_d;
  logic [7:0] cmd_pw, pw_q, pw_d, cnt_q, cnt_d;
  logic [7:0] sense_q, sense_d, count_q, count_d;
  logic       done_q, done_d, err_q, err_d, rbit_q, rbit_d;
  logic       go_q, start, busy_q, busy_d, sen_d;
  logic [7:0] wl_d, set_d, rst_d;
  logic       unused_bits;

  assign cmd_row = la_data_in[2:0];
  assign cmd_col = la_data_in[5:3];
  assign cmd_op  = op_t'(la_data_in[7:6]);
  assign cmd_pw  = la_data_in[15:8];
  assign start   = la_data_in[16] & ~go_q & (la_oenb[16:0] == '0);

  assign unused_bits = ^{la_data_in[31:17], la_oenb[31:17]};

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) state <= ST_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    row_d    = row_q;
    col_d    = col_q;
    op_d     = op_q;
    pw_d     = pw_q;
    cnt_d    = cnt_q;
    done_d   = done_q;
    err_d    = err_q;
    rbit_d   = rbit_q;
    sense_d  = sense_q;
    count_d  = count_q;

    // A rejected start only flags err; the running op and latched fields stay put.
    if (start && cmd_op != OP_NOP) begin
      if (state != ST_IDLE || cmd_pw == '0) begin
        err_d = 1'b1;
      end else begin
        row_d    = cmd_row;
        col_d    = cmd_col;
        op_d     = cmd_op;
        pw_d     = cmd_pw;
        done_d   = 1'b0;
        err_d    = 1'b0;
        state_nx = ST_SETUP;
      end
    end

    case (state)
      ST_SETUP: begin
        cnt_d    = pw_q;
        state_nx = ST_PULSE;
      end
      ST_PULSE: begin
        if (cnt_q == 8'd1) begin
          if (op_q == OP_READ) begin
            sense_d = sense_in;
            rbit_d  = sense_in[col_q];
          end
          cnt_d    = 8'(SETTLE_CYCLES);
          state_nx = ST_SETTLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_SETTLE: begin
        if (cnt_q <= 8'd1) begin
          cnt_d    = '0;
          done_d   = 1'b1;
          count_d  = count_q + 8'd1;
          state_nx = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: ;
    endcase

    // Drivers are decoded from the next state so they register in step with it.
    wl_d   = '0;
    set_d  = '0;
    rst_d  = '0;
    sen_d  = 1'b0;
    busy_d = (state_nx != ST_IDLE);
    if (state_nx == ST_SETUP || state_nx == ST_PULSE) wl_d = 8'd1 << row_d;
    if (state_nx == ST_PULSE) begin
      if (op_d == OP_SET)   set_d = 8'd1 << col_d;
      if (op_d == OP_RESET) rst_d = 8'd1 << col_d;
      if (op_d == OP_READ)  sen_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      go_q     <= 1'b1;
      row_q    <= '0;
      col_q    <= '0;
      op_q     <= OP_NOP;
      pw_q     <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rbit_q   <= 1'b0;
      sense_q  <= '0;
      count_q  <= '0;
      busy_q   <= 1'b0;
      wl_en    <= '0;
      bl_set   <= '0;
      bl_rst   <= '0;
      sense_en <= 1'b0;
    end else begin
      go_q     <= la_data_in[16];
      row_q    <= row_d;
      col_q    <= col_d;
      op_q     <= op_d;
      pw_q     <= pw_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rbit_q   <= rbit_d;
      sense_q  <= sense_d;
      count_q  <= count_d;
      busy_q   <= busy_d;
      wl_en    <= wl_d;
      bl_set   <= set_d;
      bl_rst   <= rst_d;
      sense_en <= sen_d;
    end
  end

  assign la_data_out = {12'd0, count_q, sense_q, rbit_q, err_q, done_q, busy_q};

endmodule

// File: tb/tb_crossbar_la_ctrl.sv
// Bench for crossbar_la_ctrl: cycle-position reference model plus directed literal checks.
module tb_crossbar_la_ctrl;
  localparam int unsigned S = 2;

  logic        clock = 1'b0;
  logic        resetb = 1'b0;
  logic [31:0] la_data_in = '0;
  logic [31:0] la_oenb = '1;
  logic [31:0] la_data_out;
  logic [7:0]  wl_en, bl_set, bl_rst;
  logic        sense_en;
  logic [7:0]  sense_in = '0;

  int checks = 0;
  int failures = 0;

  crossbar_la_ctrl #(.SETTLE_CYCLES(S)) dut (
    .clock(clock), .resetb(resetb), .la_data_in(la_data_in), .la_oenb(la_oenb),
    .la_data_out(la_data_out), .wl_en(wl_en), .bl_set(bl_set), .bl_rst(bl_rst),
    .sense_en(sense_en), .sense_in(sense_in)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Model: an accepted op occupies k = 0 (setup), 1..pw (pulse), pw+1..pw+S (settle).
  bit         m_goq = 1'b1, m_active = 1'b0, m_done = 1'b0, m_err = 1'b0, m_rbit = 1'b0;
  int         m_k = 0, m_row = 0, m_col = 0, m_op = 0, m_pw = 0;
  logic [7:0] m_sense = '0, m_count = '0;

  task automatic model_reset();
    m_goq = 1'b1; m_active = 1'b0; m_done = 1'b0; m_err = 1'b0; m_rbit = 1'b0;
    m_k = 0; m_row = 0; m_col = 0; m_op = 0; m_pw = 0; m_sense = '0; m_count = '0;
  endtask

  task automatic model_step();
    bit go, start, was;
    int op, pw;
    go    = la_data_in[16];
    start = go && !m_goq && (la_oenb[16:0] == 17'd0);
    m_goq = go;
    op    = int'(la_data_in[7:6]);
    pw    = int'(la_data_in[15:8]);
    was   = m_active;
    if (m_active) begin
      if (m_op == 3 && m_k == m_pw) begin
        m_sense = sense_in;
        m_rbit  = sense_in[m_col];
      end
      m_k++;
      if (m_k == 1 + m_pw + int'(S)) begin
        m_active = 1'b0; m_done = 1'b1; m_count = m_count + 8'd1;
      end
    end
    if (start && op != 0) begin
      if (was || pw == 0) m_err = 1'b1;
      else begin
        m_active = 1'b1; m_k = 0; m_done = 1'b0; m_err = 1'b0;
        m_row = int'(la_data_in[2:0]); m_col = int'(la_data_in[5:3]); m_op = op; m_pw = pw;
      end
    end
  endtask

  always @(posedge clock or negedge resetb) begin
    if (!resetb) model_reset();
    else         model_step();
  end

  // Per-cycle comparison plus event counters used by the directed checks.
  int         c_busy = 0, c_wl = 0, c_set = 0, c_rst = 0, c_sen = 0;
  logic [7:0] tgt_wl = '0, tgt_bl = '0;
  logic [7:0] e_wl, e_set, e_rst;
  logic       e_sen, e_pulse;

  always @(posedge clock) begin
    #1;
    e_pulse = m_active && m_k >= 1 && m_k <= m_pw;
    e_wl    = (m_active && m_k <= m_pw) ? (8'd1 << m_row) : 8'd0;
    e_set   = (e_pulse && m_op == 1) ? (8'd1 << m_col) : 8'd0;
    e_rst   = (e_pulse && m_op == 2) ? (8'd1 << m_col) : 8'd0;
    e_sen   = e_pulse && m_op == 3;
    check("cyc_la_data_out", la_data_out,
          {12'd0, m_count, m_sense, m_rbit, m_err, m_done, m_active});
    check("cyc_wl_en", {24'd0, wl_en}, {24'd0, e_wl});
    check("cyc_bl_set", {24'd0, bl_set}, {24'd0, e_set});
    check("cyc_bl_rst", {24'd0, bl_rst}, {24'd0, e_rst});
    check("cyc_sense_en", {31'd0, sense_en}, {31'd0, e_sen});
    if (la_data_out[0]) c_busy++;
    if (wl_en == tgt_wl) c_wl++;
    if (bl_set == tgt_bl) c_set++;
    if (bl_rst != 8'd0) c_rst++;
    if (sense_en) c_sen++;
  end

  function automatic logic [31:0] cmd(input int op, input int row, input int col,
                                      input int pw, input bit go);
    return {15'd0, go, 8'(pw), 2'(op), 3'(col), 3'(row)};
  endfunction

  task automatic clear_counts();
    c_busy = 0; c_wl = 0; c_set = 0; c_rst = 0; c_sen = 0;
  endtask

  task automatic send_now(input int op, input int row, input int col, input int pw);
    la_data_in = cmd(op, row, col, pw, 1'b1);
    @(negedge clock);
    la_data_in = cmd(op, row, col, pw, 1'b0);
  endtask

  task automatic send(input int op, input int row, input int col, input int pw);
    @(negedge clock);
    send_now(op, row, col, pw);
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 600 && !idle; i++) begin
      if (!la_data_out[0]) idle = 1'b1;
      else @(negedge clock);
    end
    if (!idle) check("idle_timeout", {31'd0, la_data_out[0]}, 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clock);
    check("reset_la_data_out", la_data_out, 32'd0);
    check("reset_drivers", {7'd0, wl_en, bl_set, bl_rst, sense_en}, 32'd0);
    resetb = 1'b1;
    la_oenb = '0;
    @(negedge clock);

    // SET row 3 col 5 pw 4
    clear_counts(); tgt_wl = 8'h08; tgt_bl = 8'h20;
    send(1, 3, 5, 4);
    wait_idle();
    check("set_busy_cycles", c_busy, 7);
    check("set_wl_cycles", c_wl, 5);
    check("set_bl_cycles", c_set, 4);
    check("set_no_rst", c_rst, 0);
    check("set_done", {31'd0, la_data_out[1]}, 32'd1);
    check("set_op_count", {24'd0, la_data_out[19:12]}, 32'd1);

    // READ row 0 col 7 pw 1
    sense_in = 8'h80;
    clear_counts(); tgt_wl = 8'h01;
    send(3, 0, 7, 1);
    wait_idle();
    check("read_sense_cycles", c_sen, 1);
    check("read_busy_cycles", c_busy, 4);
    check("read_bit", {31'd0, la_data_out[3]}, 32'd1);
    check("read_byte", {24'd0, la_data_out[11:4]}, 32'h80);

    // READ row 2 col 0 pw 3, selected bit low
    sense_in = 8'h5A;
    clear_counts(); tgt_wl = 8'h04;
    send(3, 2, 0, 3);
    wait_idle();
    check("read2_sense_cycles", c_sen, 3);
    check("read2_wl_cycles", c_wl, 4);
    check("read2_bit", {31'd0, la_data_out[3]}, 32'd0);
    check("read2_byte", {24'd0, la_data_out[11:4]}, 32'h5A);
    check("read2_op_count", {24'd0, la_data_out[19:12]}, 32'd3);

    // Starts while busy are rejected
    sense_in = 8'h00;
    clear_counts(); tgt_wl = 8'h02; tgt_bl = 8'h04;
    send(1, 1, 2, 6);
    send(2, 4, 4, 3);
    send(1, 0, 0, 0);
    wait_idle();
    check("busy_rej_busy_cycles", c_busy, 9);
    check("busy_rej_wl_cycles", c_wl, 7);
    check("busy_rej_set_cycles", c_set, 6);
    check("busy_rej_no_rst", c_rst, 0);
    check("busy_rej_err", {31'd0, la_data_out[2]}, 32'd1);
    check("busy_rej_op_count", {24'd0, la_data_out[19:12]}, 32'd4);

    // pw == 0 in IDLE is rejected
    send(2, 2, 2, 0);
    @(negedge clock);
    check("pw0_not_busy", {31'd0, la_data_out[0]}, 32'd0);
    check("pw0_err", {31'd0, la_data_out[2]}, 32'd1);

    // Accepted op clears err
    clear_counts();
    send(2, 6, 3, 2);
    wait_idle();
    check("rst_cycles", c_rst, 2);
    check("rst_err_cleared", {31'd0, la_data_out[2]}, 32'd0);
    check("rst_op_count", {24'd0, la_data_out[19:12]}, 32'd5);

    // NOP start does nothing
    send(0, 1, 1, 5);
    @(negedge clock);
    check("nop_not_busy", {31'd0, la_data_out[0]}, 32'd0);
    check("nop_no_err", {31'd0, la_data_out[2]}, 32'd0);

    // Reset mid-pulse with go held high
    @(negedge clock);
    la_data_in = cmd(1, 5, 1, 10, 1'b1);
    repeat (4) @(negedge clock);
    check("abort_pulse_active", {24'd0, bl_set}, 32'h02);
    #2 resetb = 1'b0;
    #1;
    check("abort_drivers", {7'd0, wl_en, bl_set, bl_rst, sense_en}, 32'd0);
    check("abort_la_data_out", la_data_out, 32'd0);
    @(negedge clock);
    @(negedge clock);
    resetb = 1'b1;
    repeat (6) @(negedge clock);
    check("abort_no_restart", {31'd0, la_data_out[0]}, 32'd0);
    check("abort_done", {31'd0, la_data_out[1]}, 32'd0);
    check("abort_op_count", {24'd0, la_data_out[19:12]}, 32'd0);
    la_data_in = cmd(1, 5, 1, 2, 1'b0);
    send(1, 5, 1, 2);
    wait_idle();
    check("after_abort_op_count", {24'd0, la_data_out[19:12]}, 32'd1);

    // 256 back-to-back SETs wrap op_count
    @(negedge clock); resetb = 1'b0;
    @(negedge clock); resetb = 1'b1;
    @(negedge clock);
    clear_counts();
    for (int i = 0; i < 256; i++) begin
      send_now(1, i % 8, (i / 8) % 8, 1);
      wait_idle();
      if (i == 254) check("wrap_count_255", {24'd0, la_data_out[19:12]}, 32'd255);
    end
    check("wrap_busy_cycles", c_busy, 256 * 4);
    check("wrap_op_count", {24'd0, la_data_out[19:12]}, 32'd0);
    check("wrap_done", {31'd0, la_data_out[1]}, 32'd1);

    // la_oenb[16] high blocks start and leaves err alone
    send(1, 1, 1, 0);
    @(negedge clock);
    check("oenb_pre_err", {31'd0, la_data_out[2]}, 32'd1);
    la_oenb = 32'h0001_0000;
    send(1, 1, 1, 3);
    repeat (2) @(negedge clock);
    check("oenb_not_busy", {31'd0, la_data_out[0]}, 32'd0);
    check("oenb_err_kept", {31'd0, la_data_out[2]}, 32'd1);
    check("oenb_op_count", {24'd0, la_data_out[19:12]}, 32'd0);

    // Upper la_oenb bits do not gate start
    la_oenb = 32'hFFFE_0000;
    clear_counts();
    send(2, 7, 0, 1);
    wait_idle();
    check("oenb_hi_rst_cycles", c_rst, 1);
    check("oenb_hi_op_count", {24'd0, la_data_out[19:12]}, 32'd1);
    check("oenb_hi_err", {31'd0, la_data_out[2]}, 32'd0);

    repeat (2) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
